// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-first bypass and a per-register
// busy scoreboard used by decode for RAW hazard detection.
module regfile_mp #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  busy_reg;
  logic [DEPTH-1:0]  busy_next;
  logic [ADDR_W:0]   busy_cnt_reg;
  logic [ADDR_W:0]   busy_cnt_next;
  logic              wr_ok;
  logic              iss_ok;

  // Register 0 is hardwired when ZERO_REG is set, so its writes and issues are dropped.
  assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
  assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

  // Issue is applied after writeback so a same-cycle new producer keeps the register busy.
  always_comb begin
    busy_next = busy_reg;
    if (wr_ok)
      busy_next[wr_addr] = 1'b0;
    if (iss_ok)
      busy_next[iss_addr] = 1'b1;
  end

  always_comb begin
    busy_cnt_next = '0;
    for (int i = 0; i < DEPTH; i++)
      busy_cnt_next = busy_cnt_next + (ADDR_W + 1)'(busy_next[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg     <= '0;
      busy_cnt_reg <= '0;
    end else begin
      busy_reg     <= busy_next;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_reg[i] <= '0;
    end else if (wr_ok) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  assign busy_cnt = busy_cnt_reg;

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              wr_hit;
      logic              zero_hit;
      logic [DATA_W-1:0] data_reg;

      assign addr     = rd_addr[gi*ADDR_W +: ADDR_W];
      assign wr_hit   = wr_en && (wr_addr == addr);
      assign zero_hit = (ZERO_REG != 0) && (addr == '0);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          data_reg <= '0;
        else if (rd_en[gi]) begin
          if (zero_hit)
            data_reg <= '0;
          else if (wr_hit)
            data_reg <= wr_data;
          else
            data_reg <= mem_reg[addr];
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = data_reg;
      // A writeback landing this cycle resolves the hazard, matching the bypass.
      assign rd_busy[gi] = busy_reg[addr] && !wr_hit && !zero_hit;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one instance with ZERO_REG=0 and one with ZERO_REG=1
// share directed and random stimulus and are checked against an array model.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [1:0]  rd_en;
  logic [5:0]  rd_addr;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        iss_en;
  logic [2:0]  iss_addr;

  logic [31:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic [3:0]  busy_cnt_a, busy_cnt_b;

  int errors = 0;
  int checks = 0;

  // Reference state: index 0 models ZERO_REG=0, index 1 models ZERO_REG=1.
  logic [15:0] m_mem  [2][8];
  bit          m_busy [2][8];
  logic [15:0] m_rd   [2][2];
  logic [1:0]  last_busy_a, last_busy_b;

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt_a)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] port_addr(input int k);
    logic [5:0] a;
    a = rd_addr;
    return a[k*3 +: 3];
  endfunction

  function automatic bit is_zero(input int d, input logic [2:0] a);
    return (d == 1) && (a == 3'd0);
  endfunction

  function automatic int model_cnt(input int d);
    int n = 0;
    for (int r = 0; r < 8; r++) n += m_busy[d][r] ? 1 : 0;
    return n;
  endfunction

  function automatic bit model_busy(input int d, input int k);
    logic [2:0] a;
    a = port_addr(k);
    if (is_zero(d, a)) return 1'b0;
    return m_busy[d][a] && !(wr_en && wr_addr == a);
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 8; r++) begin
        m_mem[d][r]  = 16'h0;
        m_busy[d][r] = 1'b0;
      end
      m_rd[d][0] = 16'h0;
      m_rd[d][1] = 16'h0;
    end
  endtask

  // One rising edge of the architectural rules: reads see pre-edge contents.
  task automatic model_edge();
    logic [2:0] a;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 2; k++) begin
        if (rd_en[k]) begin
          a = port_addr(k);
          if (is_zero(d, a))                   m_rd[d][k] = 16'h0;
          else if (wr_en && wr_addr == a)      m_rd[d][k] = wr_data;
          else                                 m_rd[d][k] = m_mem[d][a];
        end
      end
      if (wr_en && !is_zero(d, wr_addr)) begin
        m_mem[d][wr_addr]  = wr_data;
        m_busy[d][wr_addr] = 1'b0;
      end
      if (iss_en && !is_zero(d, iss_addr))
        m_busy[d][iss_addr] = 1'b1;
    end
  endtask

  task automatic check_regs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rd_data z0 p%0d", k), 32'(rd_data_a[k*16 +: 16]), 32'(m_rd[0][k]));
      chk($sformatf("rd_data z1 p%0d", k), 32'(rd_data_b[k*16 +: 16]), 32'(m_rd[1][k]));
    end
    chk("busy_cnt z0", 32'(busy_cnt_a), 32'(model_cnt(0)));
    chk("busy_cnt z1", 32'(busy_cnt_b), 32'(model_cnt(1)));
  endtask

  task automatic cyc(input logic [1:0] en, input logic [2:0] a0, input logic [2:0] a1,
                     input logic we, input logic [2:0] wa, input logic [15:0] wd,
                     input logic ie, input logic [2:0] ia);
    @(negedge clk);
    rd_en = en; rd_addr = {a1, a0};
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia;
    #1;
    last_busy_a = rd_busy_a;
    last_busy_b = rd_busy_b;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rd_busy z0 p%0d", k), 32'(rd_busy_a[k]), 32'(model_busy(0, k)));
      chk($sformatf("rd_busy z1 p%0d", k), 32'(rd_busy_b[k]), 32'(model_busy(1, k)));
    end
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
  endtask

  // Reset asserted between edges with every enable high: outputs clear at once
  // and the following edge must not write or issue anything.
  task automatic do_reset();
    @(negedge clk);
    rd_en = 2'b11; rd_addr = {3'd3, 3'd3};
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hDEAD;
    iss_en = 1'b1; iss_addr = 3'd3;
    rst = 1'b0;
    model_clear();
    #1;
    check_regs();
    chk("rst rd_busy z0", 32'(rd_busy_a), 32'd0);
    chk("rst rd_busy z1", 32'(rd_busy_b), 32'd0);
    @(posedge clk);
    #1;
    check_regs();
    @(negedge clk);
    rd_en = 2'b00; wr_en = 1'b0; iss_en = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    logic [3:0] cnt_before;
    rst = 1'b0;
    rd_en = 2'b00; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0;
    model_clear();
    do_reset();

    // Write r3, confirm, then reset mid-run and read it back as zero
    cyc(2'b00, 3'd0, 3'd0, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0);
    cyc(2'b01, 3'd3, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    chk("r3 before reset", 32'(rd_data_a[15:0]), 32'h0000BEEF);
    do_reset();
    cyc(2'b01, 3'd3, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    chk("r3 after reset", 32'(rd_data_a[15:0]), 32'h0);

    // Write then read on port 1, then hold with rd_en low
    cyc(2'b00, 3'd0, 3'd0, 1'b1, 3'd5, 16'h1234, 1'b0, 3'd0);
    cyc(2'b10, 3'd0, 3'd5, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    chk("r5 port1", 32'(rd_data_a[31:16]), 32'h00001234);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b00, 3'd1, 3'd2, 1'b1, 3'd5, 16'h9999, 1'b0, 3'd0);
      chk($sformatf("r5 hold %0d", i), 32'(rd_data_a[31:16]), 32'h00001234);
    end

    // Same-cycle bypass to both ports
    cyc(2'b11, 3'd2, 3'd2, 1'b1, 3'd2, 16'hA5A5, 1'b0, 3'd0);
    chk("bypass p0", 32'(rd_data_a[15:0]), 32'h0000A5A5);
    chk("bypass p1", 32'(rd_data_a[31:16]), 32'h0000A5A5);

    // Scoreboard on r4
    cyc(2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4);
    chk("issue cnt", 32'(busy_cnt_a), 32'd1);
    cyc(2'b00, 3'd4, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    chk("issue busy", 32'(last_busy_a[0]), 32'd1);
    cyc(2'b01, 3'd4, 3'd0, 1'b1, 3'd4, 16'h0042, 1'b0, 3'd0);
    chk("wb busy", 32'(last_busy_a[0]), 32'd0);
    chk("wb cnt", 32'(busy_cnt_a), 32'd0);
    chk("wb data", 32'(rd_data_a[15:0]), 32'h00000042);
    cyc(2'b00, 3'd0, 3'd0, 1'b1, 3'd4, 16'h0043, 1'b1, 3'd4);
    chk("wr+iss cnt", 32'(busy_cnt_a), 32'd1);
    cyc(2'b00, 3'd4, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    chk("wr+iss busy", 32'(last_busy_a[0]), 32'd1);
    cyc(2'b00, 3'd0, 3'd0, 1'b1, 3'd4, 16'h0044, 1'b0, 3'd0);

    // Full scoreboard, no wrap
    for (int r = 0; r < 8; r++) cyc(2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'(r));
    chk("full cnt z0", 32'(busy_cnt_a), 32'd8);
    chk("full cnt z1", 32'(busy_cnt_b), 32'd7);
    for (int r = 0; r < 8; r++) cyc(2'b00, 3'd0, 3'd0, 1'b1, 3'(r), 16'(r), 1'b0, 3'd0);
    chk("retire cnt z0", 32'(busy_cnt_a), 32'd0);
    chk("retire cnt z1", 32'(busy_cnt_b), 32'd0);

    // Register 0 behaviour with and without ZERO_REG
    cnt_before = busy_cnt_b;
    cyc(2'b00, 3'd0, 3'd0, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0);
    cyc(2'b11, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    chk("r0 z0 data", 32'(rd_data_a[15:0]), 32'h0000FFFF);
    chk("r0 z1 data", 32'(rd_data_b[31:16]), 32'h0);
    chk("r0 z0 busy", 32'(last_busy_a[1]), 32'd1);
    chk("r0 z1 busy", 32'(last_busy_b[1]), 32'd0);
    chk("r0 z1 cnt", 32'(busy_cnt_b), 32'(cnt_before));

    // Randomized traffic against the model, with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0)
        do_reset();
      else
        cyc(2'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
            16'($urandom), 1'($urandom), 3'($urandom));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
